// File: rtl/shift_seq_ctrl.sv
// Rotating LED sequencer with IDLE/RUN/PAUSE control and a modulo step counter.
// Latency: one clk from any input to every output; all outputs come straight from registers.
// Backpressure: none. Commands are prioritised load > stop > start, and any command cancels that cycle's tick.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   tick            - one-cycle step enable from the frequency divider
//   start/stop/load - control commands; load_val is the pattern captured on load
//   dir             - 0 rotates toward bit WIDTH-1, 1 rotates toward bit 0
//   led             - current rotating pattern
//   count           - steps since the last clear, 0..MAX_COUNT
//   wrap            - one-cycle pulse after count rolls over from MAX_COUNT to 0
//   running         - high while stepping is enabled
module shift_seq_ctrl #(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic [5:0]       count,
  output logic             wrap,
  output logic             running
);

  localparam logic [5:0]       CNT_MAX = 6'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [5:0]       count_q, count_d;
  logic             wrap_q, wrap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      led_q   <= LED_ONE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    count_d = count_q;
    wrap_d  = 1'b0;

    if (load) begin
      // An all-zero pattern would leave the display dark forever, so seed bit 0.
      led_d   = (load_val == '0) ? LED_ONE : load_val;
      count_d = '0;
      state_d = S_IDLE;
    end else if (stop) begin
      case (state_q)
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: begin
          state_d = S_IDLE;
          count_d = '0;
        end
        default: state_d = state_q;
      endcase
    end else if (start) begin
      // start while already running is accepted but does nothing (and still
      // swallows a coincident tick, since it is an active command).
      if (state_q != S_RUN) state_d = S_RUN;
    end else if (tick && (state_q == S_RUN)) begin
      led_d = dir ? {led_q[0], led_q[WIDTH-1:1]}
                  : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      // >= keeps count bounded even if it were ever corrupted above the limit.
      if (count_q >= CNT_MAX) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 6'd1;
      end
    end
  end

  assign led     = led_q;
  assign count   = count_q;
  assign wrap    = wrap_q;
  assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed command/tick sequences, a reference model
// checked on every falling edge, and literal expectations at key points.
module tb_shift_seq_ctrl;

  localparam int W = 6;
  localparam int MAXC = 59;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick, start, stop, dir, load;
  logic [W-1:0] load_val;
  logic [W-1:0] led;
  logic [5:0]   count;
  logic         wrap, running;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  shift_seq_ctrl #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .count    (count),
    .wrap     (wrap),
    .running  (running)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = running, 2 = paused.
  int m_mode, m_led, m_cnt, m_wrap;
  localparam int MASK = (1 << W) - 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_led = 1; m_cnt = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (load) begin
        m_led  = (int'(load_val) == 0) ? 1 : int'(load_val);
        m_cnt  = 0;
        m_mode = 0;
      end else if (stop) begin
        if (m_mode == 1) m_mode = 2;
        else if (m_mode == 2) begin m_mode = 0; m_cnt = 0; end
      end else if (start) begin
        m_mode = 1;
      end else if (tick && m_mode == 1) begin
        if (dir) m_led = (m_led >> 1) | ((m_led & 1) << (W - 1));
        else     m_led = ((m_led << 1) | (m_led >> (W - 1))) & MASK;
        m_cnt = (m_cnt + 1) % (MAXC + 1);
        if (m_cnt == 0) m_wrap = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_led",     32'(led),     32'(m_led));
      chk("model_count",   32'(count),   32'(m_cnt));
      chk("model_wrap",    32'(wrap),    32'(m_wrap));
      chk("model_running", 32'(running), 32'(m_mode == 1));
    end
  end

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic sp,
                       input logic st, input logic tk, input logic d);
    @(negedge clk);
    load = ld; load_val = lv; stop = sp; start = st; tick = tk; dir = d;
  endtask

  task automatic lit(input string tag, input int el, input int ec, input int ew, input int er);
    @(posedge clk);
    #1;
    chk({tag, "_led"},     32'(led),     32'(el));
    chk({tag, "_count"},   32'(count),   32'(ec));
    chk({tag, "_wrap"},    32'(wrap),    32'(ew));
    chk({tag, "_running"}, 32'(running), 32'(er));
  endtask

  initial begin
    rst = 1'b0; tick = 0; start = 0; stop = 0; dir = 0; load = 0; load_val = '0;
    repeat (2) @(negedge clk);
    chk("reset_led", 32'(led), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // start then three left steps
    drive(0, '0, 0, 1, 0, 0); lit("start", 1, 0, 0, 1);
    drive(0, '0, 0, 0, 1, 0); lit("left1", 2, 1, 0, 1);
    drive(0, '0, 0, 0, 1, 0); lit("left2", 4, 2, 0, 1);
    drive(0, '0, 0, 0, 1, 0); lit("left3", 8, 3, 0, 1);

    // load 100000, start, two right steps
    drive(1, 6'b100000, 0, 0, 0, 0); lit("load32", 32, 0, 0, 0);
    drive(0, '0, 0, 1, 0, 0);        lit("start2", 32, 0, 0, 1);
    drive(0, '0, 0, 0, 1, 1);        lit("right1", 16, 1, 0, 1);
    drive(0, '0, 0, 0, 1, 1);        lit("right2", 8, 2, 0, 1);
    drive(0, '0, 0, 0, 0, 1);        lit("nostep", 8, 2, 0, 1);

    // run up to the terminal count, then wrap
    for (int i = 0; i < 57; i++) drive(0, '0, 0, 0, 1, 0);
    lit("at_max", 1, 59, 0, 1);
    drive(0, '0, 0, 0, 1, 0); lit("wrap", 2, 0, 1, 1);
    drive(0, '0, 0, 0, 0, 0); lit("post_wrap", 2, 0, 0, 1);

    // stop+tick pauses without stepping, tick in pause ignored, double stop clears
    drive(0, '0, 0, 0, 1, 0); lit("pre_stop1", 4, 1, 0, 1);
    drive(0, '0, 0, 0, 1, 0); lit("pre_stop2", 8, 2, 0, 1);
    drive(0, '0, 1, 0, 1, 0); lit("stop_tick", 8, 2, 0, 0);
    drive(0, '0, 0, 0, 1, 0); lit("pause_tick", 8, 2, 0, 0);
    drive(0, '0, 0, 1, 0, 0); lit("resume", 8, 2, 0, 1);
    drive(0, '0, 0, 1, 1, 0); lit("start_tick", 8, 2, 0, 1);
    drive(0, '0, 1, 0, 0, 0); lit("pause2", 8, 2, 0, 0);
    drive(0, '0, 1, 0, 0, 0); lit("stop_idle", 8, 0, 0, 0);
    drive(0, '0, 1, 0, 1, 0); lit("stop_in_idle", 8, 0, 0, 0);

    // all three commands with a zero pattern
    drive(0, '0, 0, 1, 0, 0); lit("start3", 8, 0, 0, 1);
    drive(0, '0, 0, 0, 1, 0); lit("step16", 16, 1, 0, 1);
    drive(1, '0, 1, 1, 1, 0); lit("load_zero", 1, 0, 0, 0);

    // reach count 17 with right steps, then asynchronous reset between edges
    drive(0, '0, 0, 1, 0, 0); lit("start4", 1, 0, 0, 1);
    for (int i = 0; i < 17; i++) drive(0, '0, 0, 0, 1, 1);
    lit("cnt17", 2, 17, 0, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_led", 32'(led), 32'd1);
    chk("async_count", 32'(count), 32'd0);
    chk("async_wrap", 32'(wrap), 32'd0);
    chk("async_running", 32'(running), 32'd0);
    #1 rst = 1'b1;

    drive(0, '0, 0, 0, 1, 1); lit("idle_tick1", 1, 0, 0, 0);
    drive(0, '0, 0, 0, 1, 0); lit("idle_tick2", 1, 0, 0, 0);
    drive(0, '0, 0, 1, 0, 0); lit("start5", 1, 0, 0, 1);

    // direction change takes effect on the very next tick
    drive(0, '0, 0, 0, 1, 0);        lit("dir_l", 2, 1, 0, 1);
    drive(0, '0, 0, 0, 1, 1);        lit("dir_r", 1, 2, 0, 1);
    drive(1, 6'b101100, 0, 0, 0, 0); lit("load44", 44, 0, 0, 0);
    drive(0, '0, 0, 1, 0, 0);        lit("start6", 44, 0, 0, 1);
    drive(0, '0, 0, 0, 1, 0);        lit("rotl44", 25, 1, 0, 1);
    drive(0, '0, 0, 0, 1, 1);        lit("rotr25", 44, 2, 0, 1);
    drive(0, '0, 1, 0, 0, 0);
    drive(0, '0, 1, 0, 0, 0);        lit("final_idle", 44, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 6, LED shift register width in bits.
REQ-002 Parameter: MAX_COUNT, 59, terminal value of step counter; must fit in 6 bits.
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: tick  input  1  step enable pulse from frequency divider, one clk cycle wide.
REQ-006 Port: start  input  1  command: begin or resume stepping.
REQ-007 Port: stop  input  1  command: pause; second stop while paused returns to idle.
REQ-008 Port: dir  input  1  0 = rotate left (toward bit WIDTH-1), 1 = rotate right.
REQ-009 Port: load  input  1  command: load new LED pattern.
REQ-010 Port: load_val  input  WIDTH  pattern captured on load.
REQ-011 Port: led  output  WIDTH  current rotating pattern, registered.
REQ-012 Port: count  output  6  steps taken since last clear, binary, registered; feeds binary-to-BCD converter.
REQ-013 Port: wrap  output  1  one-cycle pulse when count wraps MAX_COUNT -> 0.
REQ-014 Port: running  output  1  high exactly while FSM is in RUN.

Function
REQ-015 FSM SHALL have three states: IDLE, RUN, PAUSE; encoding free.
REQ-016 Command priority SHALL be load > stop > start; lower-priority commands in the same cycle ignored.
REQ-017 load (any state): led <= load_val, count <= 0, state -> IDLE, next cycle.
REQ-018 load with load_val == 0: led SHALL be loaded with 1 (bit 0 set) so the pattern never goes dark.
REQ-019 start in IDLE or PAUSE: state -> RUN next cycle; led and count unchanged; start in RUN ignored.
REQ-020 stop in RUN: state -> PAUSE; led and count held.
REQ-021 stop in PAUSE: state -> IDLE and count <= 0; led held; stop in IDLE ignored.
REQ-022 In RUN with tick=1 and no command active: led rotates one position per dir and count advances by 1.
REQ-023 Left rotate: led <= {led[WIDTH-2:0], led[WIDTH-1]}; right rotate: led <= {led[0], led[WIDTH-1:1]}.
REQ-024 dir sampled in the tick cycle; changing dir mid-run takes effect on the next tick, no extra step.
REQ-025 Count at MAX_COUNT on a stepping tick: count <= 0 and wrap = 1 for exactly the following cycle; otherwise wrap = 0.
REQ-026 Any command in the same cycle as tick SHALL suppress that step (no rotate, no count change).
REQ-027 tick in IDLE or PAUSE: no effect.
REQ-028 Latency: every output change appears one clk after the causing input edge; no combinational input-to-output paths.
REQ-029 count SHALL never exceed MAX_COUNT.

Reset
REQ-030 rst=0 SHALL immediately, independent of clk, force state IDLE, led = 1 (only bit 0 set), count = 0, wrap = 0, running = 0.
REQ-031 Reset asserted mid-RUN SHALL abort stepping; after rst returns high, block waits in IDLE for start.
REQ-032 Inputs in the first clk edge after reset release SHALL be honoured normally.

Verification
REQ-033 Reset, start, 3 ticks, dir=0 -> led 000001 -> 000010 -> 000100 -> 001000, count=3, running=1.
REQ-034 Load 100000, start, 2 ticks dir=1 -> led 010000 then 001000; count=2.
REQ-035 Run to count=59, one more tick -> count=0, wrap high exactly one cycle, led continues rotating.
REQ-036 In RUN assert stop and tick same cycle -> PAUSE, no step; second stop -> IDLE, count=0, led held.
REQ-037 load=1, stop=1, start=1 with load_val=000000 in RUN -> led=000001, count=0, IDLE, running=0.
REQ-038 rst pulsed low between clk edges during RUN with count=17 -> outputs reset values before next edge; ticks ignored until start.
